// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: shared state type, slot map, decode and constants for the FP issue controller
package fpu_issue_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_COMB, S_DONE} state_t;
  typedef struct packed {
    logic       legal;
    logic       is_comb;
    logic [2:0] slot;
  } dec_t;
  localparam logic [2:0] SLOT_ADD  = 3'd0;
  localparam logic [2:0] SLOT_MUL  = 3'd1;
  localparam logic [2:0] SLOT_DIV  = 3'd2;
  localparam logic [2:0] SLOT_FMA  = 3'd3;
  localparam logic [2:0] SLOT_SQRT = 3'd4;
  localparam logic [2:0] SLOT_F2I  = 3'd5;
  localparam logic [2:0] SLOT_I2F  = 3'd6;
  localparam logic [2:0] SLOT_UI2F = 3'd7;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [2:0] RM_DYN  = 3'b111;
  localparam logic [2:0] RM_ILL5 = 3'b101;
  localparam logic [2:0] RM_ILL6 = 3'b110;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  // 100xx shares the FMA slot; 101xx maps straight onto slots 4..7
  function automatic dec_t decode_sel(input logic [4:0] sel);
    dec_t d;
    d.legal   = !(sel[4:3] == 2'b11 || sel == 5'b00100);
    d.is_comb = !sel[4] && sel > 5'b00100;
    d.slot    = sel[4] ? (sel[2] ? {1'b1, sel[1:0]} : SLOT_FMA) :
                sel == 5'b00010 ? SLOT_MUL :
                sel == 5'b00011 ? SLOT_DIV : SLOT_ADD;
    return d;
  endfunction
endpackage

// File: rtl/fpu_issue_timer.sv
// fpu_issue_timer: WAIT-state cycle counter, expires when it reaches TIMEOUT-1
module fpu_issue_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic g_clk,
  input  logic g_rst,
  input  logic load,
  input  logic tick,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = load ? '0 : tick ? count_q + 1'b1 : count_q;
  assign expire = tick && (count_q == CW'(TIMEOUT - 1));
  always_ff @(posedge g_clk or posedge g_rst)
    if (g_rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: accepts one FP op, dispatches it to an iterative unit or completes it directly
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                       g_clk,
  input  logic                       g_rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [4:0]                 op_sel,
  input  logic [2:0]                 op_rm,
  input  logic [2:0]                 frm,
  input  logic [WIDTH-1:0]           op_a,
  input  logic [WIDTH-1:0]           op_b,
  input  logic [WIDTH-1:0]           op_c,
  output logic [NUM_UNITS-1:0]       unit_start,
  output logic [WIDTH-1:0]           unit_a,
  output logic [WIDTH-1:0]           unit_b,
  output logic [WIDTH-1:0]           unit_c,
  output logic [2:0]                 unit_rm,
  output logic [1:0]                 unit_sub,
  input  logic [NUM_UNITS-1:0]       unit_done,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_res,
  input  logic [NUM_UNITS*5-1:0]     unit_flags,
  input  logic [WIDTH-1:0]           comb_res,
  output logic                       res_valid,
  output logic [WIDTH-1:0]           res_data,
  output logic                       stall,
  output logic [4:0]                 fflags,
  input  logic                       fflags_clr,
  output logic                       timeout_err
);
  localparam logic [WIDTH-1:0] NAN_W = WIDTH'(CANON_NAN);
  localparam logic [WIDTH-1:0] SIGN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NUM_UNITS-1:0] ONE = {{(NUM_UNITS-1){1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [2:0] slot_q, slot_d, rm_q, rm_d, rm_res;
  logic [1:0] sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
  logic [4:0] fflags_q, fflags_d, cflags;
  logic [NUM_UNITS-1:0] start_q, start_d;
  logic tmo_q, tmo_d, ready_q, ready_d, valid_q, valid_d;
  logic accept, ill, done_hit, expire;
  dec_t dec;
  fpu_issue_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .g_clk(g_clk), .g_rst(g_rst),
    .load(state_q == S_START), .tick(state_q == S_WAIT), .expire(expire)
  );
  always_comb begin
    dec      = decode_sel(op_sel);
    rm_res   = (op_rm == RM_DYN) ? frm : op_rm;
    ill      = !dec.legal || rm_res == RM_ILL5 || rm_res == RM_ILL6;
    accept   = op_valid & ready_q;
    done_hit = (state_q == S_WAIT) && unit_done[slot_q];
    slot_d   = accept ? dec.slot : slot_q;
    a_d      = accept ? op_a : a_q;
    b_d      = accept ? ((op_sel == 5'b00001) ? op_b ^ SIGN : op_b) : b_q;
    c_d      = accept ? op_c : c_q;
    rm_d     = accept ? rm_res : rm_q;
    sub_d    = accept ? op_sel[1:0] : sub_q;
    state_d  = state_q;
    res_d    = res_q;
    cflags   = '0;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = ill ? S_DONE : dec.is_comb ? S_COMB : S_START;
        res_d = ill ? NAN_W : res_q;
        cflags[FLAG_NV] = ill;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: if (done_hit) begin
        state_d = S_DONE;
        res_d = unit_res[slot_q*WIDTH +: WIDTH];
        cflags = unit_flags[slot_q*5 +: 5];
      end else if (expire) begin
        state_d = S_DONE;
        res_d = NAN_W;
        cflags[FLAG_NV] = 1'b1;
        tmo_d = 1'b1;
      end
      S_COMB: begin
        state_d = S_DONE;
        res_d = comb_res;
      end
      default: state_d = S_IDLE;
    endcase
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | cflags;
    ready_d  = state_d == S_IDLE;
    valid_d  = state_d == S_DONE;
    start_d  = (state_d == S_START) ? ONE << slot_d : '0;
  end
  always_ff @(posedge g_clk or posedge g_rst)
    if (g_rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      rm_q     <= '0;
      sub_q    <= '0;
      res_q    <= '0;
      fflags_q <= '0;
      tmo_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      start_q  <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      rm_q     <= rm_d;
      sub_q    <= sub_d;
      res_q    <= res_d;
      fflags_q <= fflags_d;
      tmo_q    <= tmo_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
    end
  assign op_ready    = ready_q;
  assign unit_start  = start_q;
  assign unit_a      = a_q;
  assign unit_b      = b_q;
  assign unit_c      = c_q;
  assign unit_rm     = rm_q;
  assign unit_sub    = sub_q;
  assign res_valid   = valid_q;
  assign res_data    = res_q;
  assign stall       = op_valid & ~ready_q;
  assign fflags      = fflags_q;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scenario tests for the FP issue controller
module tb_fpu_issue_ctrl;
  localparam int W = 32;
  localparam int N = 8;
  localparam int TMO = 64;
  logic g_clk = 1'b0, g_rst = 1'b1;
  logic op_valid = 1'b0, op_ready, stall, res_valid, fflags_clr = 1'b0, timeout_err;
  logic [4:0] op_sel = '0, fflags;
  logic [2:0] op_rm = '0, frm = '0, unit_rm;
  logic [1:0] unit_sub;
  logic [W-1:0] op_a = '0, op_b = '0, op_c = '0, unit_a, unit_b, unit_c, comb_res = '0, res_data;
  logic [N-1:0] unit_start, unit_done = '0;
  logic [N*W-1:0] unit_res = '0;
  logic [N*5-1:0] unit_flags = '0;
  int pass_cnt = 0, total_cnt = 0;
  fpu_issue_ctrl #(.WIDTH(W), .NUM_UNITS(N), .TIMEOUT(TMO)) dut (
    .g_clk(g_clk), .g_rst(g_rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_sel(op_sel), .op_rm(op_rm), .frm(frm), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c),
    .unit_rm(unit_rm), .unit_sub(unit_sub), .unit_done(unit_done), .unit_res(unit_res),
    .unit_flags(unit_flags), .comb_res(comb_res), .res_valid(res_valid), .res_data(res_data),
    .stall(stall), .fflags(fflags), .fflags_clr(fflags_clr), .timeout_err(timeout_err)
  );
  always #5 g_clk = ~g_clk;
  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) tick;
    g_rst = 1'b0;
    tick;
    total_cnt++; if (op_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", op_ready); else pass_cnt++;
    total_cnt++; if ({unit_start, res_valid} !== 9'h0) $display("FAIL rst_start_valid got %h want 0", {unit_start, res_valid}); else pass_cnt++;
    total_cnt++; if ({res_data, unit_a, unit_b, unit_c} !== '0) $display("FAIL rst_data got %h want 0", {res_data, unit_a, unit_b, unit_c}); else pass_cnt++;
    total_cnt++; if ({unit_rm, unit_sub, fflags, timeout_err} !== 11'h0) $display("FAIL rst_misc got %h want 0", {unit_rm, unit_sub, fflags, timeout_err}); else pass_cnt++;
  endtask
  task automatic test_fadd;
    op_sel = 5'b00000; op_rm = 3'b000; op_a = 32'h3F800000; op_b = 32'h40000000; op_c = 32'h1234_5678;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    total_cnt++; if (unit_start !== 8'h01) $display("FAIL fadd_start got %h want 01", unit_start); else pass_cnt++;
    total_cnt++; if ({unit_a, unit_b, unit_c} !== {32'h3F800000, 32'h40000000, 32'h12345678}) $display("FAIL fadd_ops got %h want 3f80000040000000 12345678", {unit_a, unit_b, unit_c}); else pass_cnt++;
    tick;
    total_cnt++; if (unit_start !== 8'h00) $display("FAIL fadd_start_pulse got %h want 00", unit_start); else pass_cnt++;
    unit_done = 8'h02;
    op_valid = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL fadd_stall got %b want 1", stall); else pass_cnt++;
    tick;
    op_valid = 1'b0;
    unit_done = 8'h00;
    unit_res[31:0] = 32'h40400000; unit_flags[4:0] = 5'b0;
    tick;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL fadd_other_done got %b want 0", res_valid); else pass_cnt++;
    unit_done = 8'h01;
    tick;
    unit_done = 8'h00;
    total_cnt++; if ({res_valid, res_data} !== {1'b1, 32'h40400000}) $display("FAIL fadd_result got %h want 140400000", {res_valid, res_data}); else pass_cnt++;
    tick;
    total_cnt++; if ({res_valid, op_ready, res_data} !== {2'b01, 32'h40400000}) $display("FAIL fadd_after got %h want 140400000", {res_valid, op_ready, res_data}); else pass_cnt++;
  endtask
  task automatic test_fsub_dyn;
    op_sel = 5'b00001; op_rm = 3'b111; frm = 3'b010; op_b = 32'h40000000;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    total_cnt++; if (unit_b !== 32'hC0000000) $display("FAIL fsub_neg_b got %h want c0000000", unit_b); else pass_cnt++;
    total_cnt++; if ({unit_rm, unit_sub} !== {3'b010, 2'b01}) $display("FAIL fsub_rm_sub got %b want 01001", {unit_rm, unit_sub}); else pass_cnt++;
    tick;
    unit_res[31:0] = 32'hBF800000; unit_done = 8'h01;
    tick;
    unit_done = 8'h00;
    total_cnt++; if ({res_valid, res_data} !== {1'b1, 32'hBF800000}) $display("FAIL fsub_result got %h want 1bf800000", {res_valid, res_data}); else pass_cnt++;
    tick;
    op_rm = 3'b000;
  endtask
  task automatic test_comb;
    op_sel = 5'b01000; comb_res = 32'h41200000;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    total_cnt++; if ({res_valid, unit_start} !== 9'h0) $display("FAIL comb_c1 got %h want 0", {res_valid, unit_start}); else pass_cnt++;
    tick;
    total_cnt++; if ({res_valid, res_data} !== {1'b1, 32'h41200000}) $display("FAIL comb_result got %h want 141200000", {res_valid, res_data}); else pass_cnt++;
    total_cnt++; if (fflags !== 5'b00000) $display("FAIL comb_flags got %b want 00000", fflags); else pass_cnt++;
    tick;
  endtask
  task automatic test_illegal;
    op_sel = 5'b00100;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    total_cnt++; if ({res_valid, res_data} !== {1'b1, 32'h7FC00000}) $display("FAIL ill_sel_result got %h want 17fc00000", {res_valid, res_data}); else pass_cnt++;
    total_cnt++; if (fflags !== 5'b10000) $display("FAIL ill_sel_flags got %b want 10000", fflags); else pass_cnt++;
    tick;
    total_cnt++; if ({op_ready, res_valid} !== 2'b10) $display("FAIL ill_ready got %b want 10", {op_ready, res_valid}); else pass_cnt++;
    op_sel = 5'b00000; op_rm = 3'b101;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0; op_rm = 3'b000;
    total_cnt++; if ({res_valid, unit_start, res_data} !== {1'b1, 8'h00, 32'h7FC00000}) $display("FAIL ill_rm got %h want 1007fc00000", {res_valid, unit_start, res_data}); else pass_cnt++;
    tick;
    fflags_clr = 1'b1;
    tick;
    fflags_clr = 1'b0;
    total_cnt++; if (fflags !== 5'b00000) $display("FAIL flags_clear got %b want 00000", fflags); else pass_cnt++;
  endtask
  task automatic test_timeout;
    op_sel = 5'b00011;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    total_cnt++; if (unit_start !== 8'h04) $display("FAIL div_start got %h want 04", unit_start); else pass_cnt++;
    repeat (TMO) tick;
    total_cnt++; if ({res_valid, timeout_err} !== 2'b00) $display("FAIL tmo_early got %b want 00", {res_valid, timeout_err}); else pass_cnt++;
    tick;
    total_cnt++; if ({res_valid, res_data} !== {1'b1, 32'h7FC00000}) $display("FAIL tmo_result got %h want 17fc00000", {res_valid, res_data}); else pass_cnt++;
    total_cnt++; if ({timeout_err, fflags} !== 6'b110000) $display("FAIL tmo_flags got %b want 110000", {timeout_err, fflags}); else pass_cnt++;
    tick;
    unit_res[95:64] = 32'h3F000000; unit_done = 8'h04;
    tick;
    unit_done = 8'h00;
    tick;
    total_cnt++; if ({res_valid, op_ready, timeout_err, res_data} !== {3'b011, 32'h7FC00000}) $display("FAIL tmo_late_done got %h want 37fc00000", {res_valid, op_ready, timeout_err, res_data}); else pass_cnt++;
  endtask
  task automatic test_reset_wait;
    op_sel = 5'b00000; op_a = 32'h3F800000; op_b = 32'h40000000; op_rm = 3'b011;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0; op_rm = 3'b000;
    tick;
    g_rst = 1'b1;
    #1;
    total_cnt++; if ({op_ready, res_valid, unit_start} !== {2'b10, 8'h00}) $display("FAIL rstw_ctrl got %h want 200", {op_ready, res_valid, unit_start}); else pass_cnt++;
    total_cnt++; if ({res_data, unit_a, unit_b, unit_c} !== '0) $display("FAIL rstw_data got %h want 0", {res_data, unit_a, unit_b, unit_c}); else pass_cnt++;
    total_cnt++; if ({unit_rm, unit_sub, fflags, timeout_err} !== 11'h0) $display("FAIL rstw_misc got %h want 0", {unit_rm, unit_sub, fflags, timeout_err}); else pass_cnt++;
    tick;
    g_rst = 1'b0;
    unit_done = 8'h01;
    tick;
    unit_done = 8'h00;
    tick;
    total_cnt++; if ({res_valid, op_ready, res_data} !== {2'b01, 32'h0}) $display("FAIL rstw_late_done got %h want 100000000", {res_valid, op_ready, res_data}); else pass_cnt++;
  endtask
  task automatic test_fflags_clr;
    op_sel = 5'b11000;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    total_cnt++; if (fflags !== 5'b10000) $display("FAIL clr_pre got %b want 10000", fflags); else pass_cnt++;
    tick;
    op_sel = 5'b00000;
    op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    tick;
    unit_res[31:0] = 32'h40A00000; unit_flags[4:0] = 5'b00001; unit_done = 8'h01; fflags_clr = 1'b1;
    tick;
    unit_done = 8'h00; fflags_clr = 1'b0;
    total_cnt++; if ({res_valid, fflags} !== 6'b100001) $display("FAIL clr_coincide got %b want 100001", {res_valid, fflags}); else pass_cnt++;
    tick;
  endtask
  initial begin
    test_reset;
    test_fadd;
    test_fsub_dyn;
    test_comb;
    test_illegal;
    test_timeout;
    test_reset_wait;
    test_fflags_clr;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Parametrised issue/completion controller for the RV32F execute stage. It accepts one FP operation per handshake and dispatches it to one of NUM_UNITS iterative units through a start/done handshake, or completes combinational ops directly. It returns one result per operation, resolves the dynamic rounding mode, accumulates sticky fflags and bounds every unit wait with a timeout. It replaces the fixed select-and-stall control inside the FPU; operand muxing and the arithmetic units stay outside.

## Interface
- WIDTH, 32, operand/result width.
- NUM_UNITS, 8, number of iterative unit slots; minimum 8, since slots 0-7 are fixed by the decode map.
- TIMEOUT, 64, maximum cycles in WAIT before forced completion; must be at least 2.
- g_clk  in  1  clock.
- g_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- op_valid  in  1  operation offered.
- op_ready  out  1  controller can accept.
- op_sel  in  5  fpusel code.
- op_rm  in  3  instruction rounding mode.
- frm  in  3  CSR rounding mode, used when op_rm==3'b111.
- op_a, op_b, op_c  in  WIDTH  operands.
- unit_start  out  NUM_UNITS  one-hot start pulse.
- unit_a, unit_b, unit_c  out  WIDTH  registered operands, held from accept until the next accept.
- unit_rm  out  3  resolved rounding mode.
- unit_sub  out  2  op_sel[1:0], the FMA variant.
- unit_done  in  NUM_UNITS  per-unit completion pulse.
- unit_res  in  NUM_UNITS*WIDTH  packed unit results.
- unit_flags  in  NUM_UNITS*5  packed unit exception flags.
- comb_res  in  WIDTH  result of the combinational ops, computed from unit_a/unit_b.
- res_valid  out  1  one-cycle result pulse.
- res_data  out  WIDTH  result, held until the next res_valid.
- stall  out  1  op_valid & ~op_ready.
- fflags  out  5  sticky NV,DZ,OF,UF,NX.
- fflags_clr  in  1  clear fflags.
- timeout_err  out  1  sticky; set on any timeout.

## Operation
- States:
  - IDLE: op_ready=1.
  - START: unit_start[idx]=1 for exactly one cycle.
  - WAIT: counting; waiting for unit_done[idx].
  - COMB: sample comb_res.
  - DONE: res_valid=1.
- On accept (op_valid & op_ready), register operands. For op_sel==5'b00001 (fsub), register b with its sign bit inverted. Resolve rm: 3'b111 selects frm.
- Decode op_sel:
  - Slot map: 00000/00001 -> slot 0; 00010 -> 1; 00011 -> 2; 100xx -> 3; 10100 -> 4; 10101 -> 5; 10110 -> 6; 10111 -> 7.
  - 00101..01111 are combinational.
  - 00100, 11xxx, and any resolved rm of 5 or 6 are illegal.
- Transitions:
  - IDLE -> START for slot ops.
  - IDLE -> COMB for combinational ops.
  - IDLE -> DONE for illegal ops; res_data=canonical NaN, NV set.
  - START -> WAIT.
  - WAIT -> DONE when unit_done[idx]=1: capture unit_res/unit_flags of idx.
  - WAIT -> DONE when the counter reaches TIMEOUT-1 without done: canonical NaN, NV set, timeout_err set.
  - COMB -> DONE: capture comb_res, flags 0.
  - DONE -> IDLE.
- unit_done of a non-selected slot, or of any slot outside WAIT, is ignored.
- fflags update: next = (fflags_clr ? 0 : fflags) | completing_flags. A clear that coincides with a completion keeps the new flags.
- timeout_err clears only on reset.

## Timing
- Reset values:
  - state IDLE, op_ready=1, unit_start=0, res_valid=0.
  - res_data=0, unit_a/b/c=0, unit_rm=0, unit_sub=0.
  - fflags=0, timeout_err=0, counter=0.
- Accept at cycle 0:
  - Slot op: unit_start at cycle 1. If done arrives at cycle k≥2 (done sampled in WAIT), res_valid is at cycle k+1.
  - Combinational op: res_valid at cycle 2.
  - Illegal op: res_valid at cycle 1.
- Next accept is no earlier than the cycle after res_valid; op_ready returns to 1 in that cycle.
- Timeout: res_valid at cycle TIMEOUT+2 after accept.
- Reset asserted mid-operation returns to IDLE immediately with no res_valid. A done arriving after reset release is ignored.

## Structure
- Package fpu_issue_pkg holds:
  - state enum;
  - slot index constants (SLOT_ADD..SLOT_UI2F);
  - function decode_sel(sel) returning {legal, is_comb, slot};
  - canonical NaN constant (32'h7FC00000, width-adapted);
  - RM_DYN/RM_illegal constants and flag bit positions.
- Sub-module fpu_issue_timer: the WAIT counter, with load/tick/expire outputs.

## Test plan
- fadd, a=0x3F800000, b=0x40000000, unit0 done 3 cycles after start with res 0x40400000, flags 0 -> unit_start[0] at cycle 1, res_valid at cycle 5 with res_data=0x40400000.
- fsub, b=0x40000000 -> unit_b=0xC0000000; op_rm=3'b111, frm=3'b010 -> unit_rm=3'b010.
- op_sel=5'b01000 (fmax), comb_res=0x41200000 -> res_valid at cycle 2 with that value, fflags unchanged.
- op_sel=5'b00100 -> res_valid at cycle 1, res_data=0x7FC00000, fflags=5'b10000.
- fdiv with no done, TIMEOUT=64 -> res_valid at cycle 66, NaN result, timeout_err=1; a later done pulse is ignored.
- Reset asserted in WAIT -> all outputs at reset values. Separately: fflags_clr coincident with a completion carrying flags 5'b00001 -> fflags=5'b00001.
